// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshake data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Misaligned or outside the DEPTH-word window starting at base; 33-bit span avoids wrap.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [31:0] off;
    logic [32:0] span;
    off  = addr - base;
    span = 33'(depth) * 33'(WORD_BYTES);
    return (addr[1:0] != 2'b00) || ({1'b0, off} >= span);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// DEPTH x 32 word RAM with four byte-lane write enables and a combinational read port.
module dmem_word_array #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                       clock,
  input  logic                       we,
  input  logic [3:0]                 be,
  input  logic [$clog2(DEPTH)-1:0]   widx,
  input  logic [31:0]                wdata,
  input  logic [$clog2(DEPTH)-1:0]   ridx,
  output logic [31:0]                rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: valid/ready request and response channels with
// LATENCY edges between request acceptance and response valid.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               write_q, write_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               accept;
  logic               req_err;
  logic [IDX_W-1:0]   req_idx;
  logic [IDX_W-1:0]   ram_ridx;
  logic [31:0]        ram_rdata;
  logic               ram_we;

  assign accept  = (state_q == IDLE) && req_valid;
  assign req_err = addr_err(req_addr, BASE_ADDR, DEPTH);
  assign req_idx = IDX_W'((req_addr - BASE_ADDR) >> 2);
  assign ram_we  = accept && req_write && !req_err;
  // With LATENCY = 1 the response is loaded on the acceptance edge, so read via the live address.
  assign ram_ridx = (state_q == IDLE) ? req_idx : idx_q;

  dmem_word_array #(.DEPTH(DEPTH)) u_array (
    .clock (clock),
    .we    (ram_we),
    .be    (req_be),
    .widx  (req_idx),
    .wdata (req_wdata),
    .ridx  (ram_ridx),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    write_d   = write_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_idx;
          write_d = req_write;
          err_d   = req_err;
          if (LATENCY == 1) begin
            state_d   = RESP;
            rdata_d   = (!req_write && !req_err) ? ram_rdata : 32'h0;
            rsp_err_d = req_err;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          rdata_d   = (!write_q && !err_q) ? ram_rdata : 32'h0;
          rsp_err_d = err_q;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d   = IDLE;
          rdata_d   = 32'h0;
          rsp_err_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= 32'h0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
